// File: rtl/axi4lite_ctrl_regfile_if.sv
// AXI4-Lite bus bundle for the control register file: slave side faces the PS interconnect.
interface axi4lite_ctrl_regfile_if #(
    parameter int unsigned ADDR_WIDTH = 40
);
    logic [ADDR_WIDTH-1:0] awaddr;
    logic                  awvalid;
    logic                  awready;
    logic [31:0]           wdata;
    logic [3:0]            wstrb;
    logic                  wvalid;
    logic                  wready;
    logic [1:0]            bresp;
    logic                  bvalid;
    logic                  bready;
    logic [ADDR_WIDTH-1:0] araddr;
    logic                  arvalid;
    logic                  arready;
    logic [31:0]           rdata;
    logic [1:0]            rresp;
    logic                  rvalid;
    logic                  rready;

    modport slave (
        input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
        output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );

    modport master (
        output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
        input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );
endinterface

// File: rtl/axi4lite_ctrl_regfile.sv
// AXI4-Lite register file for the move-generator control path: control regs with pulse bits,
// status words, a writable board buffer and a read-only board window.
module axi4lite_ctrl_regfile #(
    parameter int unsigned            ADDR_WIDTH  = 40,
    parameter int unsigned            NUM_CTRL    = 8,
    parameter int unsigned            NUM_STATUS  = 16,
    parameter int unsigned            PIECE_WIDTH = 4,
    parameter int unsigned            SQUARES     = 64,
    parameter logic [NUM_CTRL*32-1:0] PULSE_MASK  = '0,
    parameter logic [NUM_CTRL*32-1:0] CTRL_RESET  = '0
) (
    input  logic                           clk,
    input  logic                           reset,
    axi4lite_ctrl_regfile_if.slave         axi,
    output logic [NUM_CTRL*32-1:0]         ctrl_regs,
    output logic [NUM_CTRL-1:0]            ctrl_wr_stb,
    output logic [SQUARES*PIECE_WIDTH-1:0] new_board,
    input  logic [NUM_STATUS*32-1:0]       status_in,
    input  logic [SQUARES*PIECE_WIDTH-1:0] rd_board
);
    localparam int unsigned IDX_W       = 14;
    localparam int unsigned STATUS_BASE = 64;
    localparam int unsigned BOARD_BASE  = 128;
    localparam int unsigned RDBRD_BASE  = 256;
    localparam logic [1:0]  RESP_OKAY   = 2'b00;
    localparam logic [1:0]  RESP_SLVERR = 2'b10;

    logic                   aw_empty_q, w_empty_q, ar_ready_q;
    logic [IDX_W-1:0]       aw_idx_q;
    logic [31:0]            w_data_q;
    logic [3:0]             w_strb_q;
    logic                   bvalid_q, rvalid_q;
    logic [1:0]             bresp_q, rresp_q;
    logic [31:0]            rdata_q;
    logic [31:0]            ctrl_q  [NUM_CTRL];
    logic [31:0]            ctrl_d  [NUM_CTRL];
    logic [NUM_CTRL-1:0]    stb_d, stb_q;
    logic [PIECE_WIDTH-1:0] board_q [SQUARES];

    logic             aw_hs, w_hs, ar_hs, commit;
    logic [IDX_W-1:0] ar_idx;
    logic [31:0]      rd_data_c;
    logic [1:0]       rd_resp_c;
    logic             unused_addr_bits;

    assign unused_addr_bits = ^{axi.awaddr[ADDR_WIDTH-1:16], axi.awaddr[1:0],
                                axi.araddr[ADDR_WIDTH-1:16], axi.araddr[1:0]};

    function automatic logic is_mapped(input logic [IDX_W-1:0] idx);
        return (idx < IDX_W'(NUM_CTRL))
            || (idx >= IDX_W'(STATUS_BASE) && idx < IDX_W'(STATUS_BASE + NUM_STATUS))
            || (idx >= IDX_W'(BOARD_BASE)  && idx < IDX_W'(BOARD_BASE + SQUARES))
            || (idx >= IDX_W'(RDBRD_BASE)  && idx < IDX_W'(RDBRD_BASE + SQUARES));
    endfunction

    assign aw_hs  = axi.awvalid & aw_empty_q;
    assign w_hs   = axi.wvalid & w_empty_q;
    assign ar_hs  = axi.arvalid & ar_ready_q;
    assign commit = ~aw_empty_q & ~w_empty_q & ~bvalid_q;
    assign ar_idx = axi.araddr[15:2];

    assign axi.awready = aw_empty_q;
    assign axi.wready  = w_empty_q;
    assign axi.bvalid  = bvalid_q;
    assign axi.bresp   = bresp_q;
    assign axi.arready = ar_ready_q;
    assign axi.rvalid  = rvalid_q;
    assign axi.rdata   = rdata_q;
    assign axi.rresp   = rresp_q;
    assign ctrl_wr_stb = stb_q;

    always_comb begin
        for (int i = 0; i < NUM_CTRL; i++) ctrl_regs[32*i +: 32] = ctrl_q[i];
        for (int s = 0; s < SQUARES; s++) new_board[s*PIECE_WIDTH +: PIECE_WIDTH] = board_q[s];
    end

    // AW/W holders and write response; holders free on commit, B waits for bready
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            aw_empty_q <= 1'b1;
            w_empty_q  <= 1'b1;
            aw_idx_q   <= '0;
            w_data_q   <= '0;
            w_strb_q   <= '0;
            bvalid_q   <= 1'b0;
            bresp_q    <= RESP_OKAY;
        end else begin
            if (aw_hs) begin
                aw_empty_q <= 1'b0;
                aw_idx_q   <= axi.awaddr[15:2];
            end else if (commit) begin
                aw_empty_q <= 1'b1;
            end
            if (w_hs) begin
                w_empty_q <= 1'b0;
                w_data_q  <= axi.wdata;
                w_strb_q  <= axi.wstrb;
            end else if (commit) begin
                w_empty_q <= 1'b1;
            end
            if (commit) begin
                bvalid_q <= 1'b1;
                bresp_q  <= is_mapped(aw_idx_q) ? RESP_OKAY : RESP_SLVERR;
            end else if (axi.bready) begin
                bvalid_q <= 1'b0;
            end
        end
    end

    // Pulse bits clear every cycle; a commit merges strobed bytes on top
    always_comb begin
        for (int i = 0; i < NUM_CTRL; i++) begin
            ctrl_d[i] = ctrl_q[i] & ~PULSE_MASK[32*i +: 32];
            stb_d[i]  = commit && (aw_idx_q == IDX_W'(i));
            if (stb_d[i]) begin
                for (int b = 0; b < 4; b++)
                    if (w_strb_q[b]) ctrl_d[i][8*b +: 8] = w_data_q[8*b +: 8];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_CTRL; i++) ctrl_q[i] <= CTRL_RESET[32*i +: 32];
            for (int s = 0; s < SQUARES; s++) board_q[s] <= '0;
            stb_q <= '0;
        end else begin
            for (int i = 0; i < NUM_CTRL; i++) ctrl_q[i] <= ctrl_d[i];
            for (int s = 0; s < SQUARES; s++)
                if (commit && w_strb_q[0] && (aw_idx_q == IDX_W'(BOARD_BASE + s)))
                    board_q[s] <= w_data_q[PIECE_WIDTH-1:0];
            stb_q <= stb_d;
        end
    end

    // Read mux sees pre-commit register state
    always_comb begin
        rd_data_c = '0;
        rd_resp_c = is_mapped(ar_idx) ? RESP_OKAY : RESP_SLVERR;
        for (int i = 0; i < NUM_CTRL; i++)
            if (ar_idx == IDX_W'(i)) rd_data_c = ctrl_q[i];
        for (int i = 0; i < NUM_STATUS; i++)
            if (ar_idx == IDX_W'(STATUS_BASE + i)) rd_data_c = status_in[32*i +: 32];
        for (int s = 0; s < SQUARES; s++) begin
            if (ar_idx == IDX_W'(BOARD_BASE + s)) rd_data_c = 32'(board_q[s]);
            if (ar_idx == IDX_W'(RDBRD_BASE + s))
                rd_data_c = 32'(rd_board[s*PIECE_WIDTH +: PIECE_WIDTH]);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ar_ready_q <= 1'b1;
            rvalid_q   <= 1'b0;
            rdata_q    <= '0;
            rresp_q    <= RESP_OKAY;
        end else if (ar_hs) begin
            ar_ready_q <= 1'b0;
            rvalid_q   <= 1'b1;
            rdata_q    <= rd_data_c;
            rresp_q    <= rd_resp_c;
        end else if (rvalid_q && axi.rready) begin
            ar_ready_q <= 1'b1;
            rvalid_q   <= 1'b0;
        end
    end
endmodule
